// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm ringing controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_e;

  // Seconds into a RING entry after which the buzzer stops pulsing and
  // stays on (only used when ALARM_ESCALATE_EN is defined).
  localparam int ESCALATE_SEC = 10;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector with a registered previous value.
// The previous value resets to 0, so a level already high when reset is
// released is reported as an edge on the first tick.
module edge_det (
  input  logic clk_1s,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // Remember last tick's level.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ringing controller: beeps the buzzer while the clock core's alarm
// is latched, handles snooze/stop buttons, re-arms after the snooze
// interval and auto-silences an unattended alarm (setting a sticky
// "missed" flag). Acknowledging transitions out of RING return a one-tick
// stop_al pulse that clears the core's alarm latch.
//
// Build option: define ALARM_ESCALATE_EN to hold the buzzer continuously
// on once a RING entry has lasted ESCALATE_SEC seconds.
module alarm_snooze_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       alarm_in,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzz,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic       stop_al,
  output logic       missed
);

  localparam int RW = $clog2(RING_TIMEOUT_SEC);
  localparam int SW = $clog2(SNOOZE_SEC);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_SEC - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SEC - 1);
  localparam logic [1:0]    MAX_SNZ   = 2'(MAX_SNOOZES);

  logic alarm_rise, snooze_rise, stop_rise;

  edge_det u_alarm_edge (
    .clk_1s (clk_1s),
    .reset  (reset),
    .sig_i  (alarm_in),
    .rise_o (alarm_rise)
  );

  edge_det u_snooze_edge (
    .clk_1s (clk_1s),
    .reset  (reset),
    .sig_i  (snooze_btn),
    .rise_o (snooze_rise)
  );

  edge_det u_stop_edge (
    .clk_1s (clk_1s),
    .reset  (reset),
    .sig_i  (stop_btn),
    .rise_o (stop_rise)
  );

  alarm_state_e  state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [1:0]    snooze_cnt_q, snooze_cnt_d;
  logic          missed_q, missed_d;
  logic          stop_al_q, stop_al_d;
  logic          buzz_q, buzz_d;
  logic          ringing_q, ringing_d;
  logic          snoozing_q, snoozing_d;

  // Next-state logic; outputs are derived from the next state so that they
  // come straight out of flops.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_cnt_d    = snz_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;
    stop_al_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (stop_rise) missed_d = 1'b0;
        if (alarm_rise) begin
          state_d      = ST_RING;
          ring_cnt_d   = '0;
          snooze_cnt_d = 2'd0;
        end
      end

      ST_RING: begin
        // Saturate rather than wrap; the timeout exit fires at RING_LAST.
        if (ring_cnt_q != RING_LAST) ring_cnt_d = ring_cnt_q + 1'b1;
        if (stop_rise) begin
          state_d      = ST_IDLE;
          stop_al_d    = 1'b1;
          snooze_cnt_d = 2'd0;
          missed_d     = 1'b0;
        end else if (snooze_rise && (snooze_cnt_q < MAX_SNZ)) begin
          state_d      = ST_SNOOZE;
          snooze_cnt_d = snooze_cnt_q + 2'd1;
          snz_cnt_d    = SNZ_LOAD;
          stop_al_d    = 1'b1;
        end else if (ring_cnt_q == RING_LAST) begin
          state_d      = ST_IDLE;
          missed_d     = 1'b1;
          stop_al_d    = 1'b1;
          snooze_cnt_d = 2'd0;
        end
      end

      ST_SNOOZE: begin
        // The core latch was already cleared on snooze entry, so a stop
        // here needs no stop_al pulse.
        if (stop_rise) begin
          state_d      = ST_IDLE;
          snooze_cnt_d = 2'd0;
        end else if (snz_cnt_q == '0) begin
          state_d    = ST_RING;
          ring_cnt_d = '0;
        end else begin
          snz_cnt_d = snz_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
`ifdef ALARM_ESCALATE_EN
    buzz_d = ringing_d & (~ring_cnt_d[0] | (32'(ring_cnt_d) >= ESCALATE_SEC));
`else
    buzz_d = ringing_d & ~ring_cnt_d[0];
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      snooze_cnt_q <= 2'd0;
      missed_q     <= 1'b0;
      stop_al_q    <= 1'b0;
      buzz_q       <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      stop_al_q    <= stop_al_d;
      buzz_q       <= buzz_d;
      ringing_q    <= ringing_d;
      snoozing_q   <= snoozing_d;
    end
  end

  assign buzz       = buzz_q;
  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = snooze_cnt_q;
  assign stop_al    = stop_al_q;
  assign missed     = missed_q;

endmodule
